// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, FSM states,
// ALU op codes (also used by the ALU block) and decoded-instruction record.
package ctrl_pkg;

  localparam int PC_W_DEF = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_MOV = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_LDS = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_READ_A, ST_READ_B, ST_WRITE, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CL_NOP, CL_MOV, CL_ALU, CL_LDS, CL_JMP, CL_HLT, CL_ILL
  } class_e;

  typedef struct packed {
    class_e     cls;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [1:0] alu_op;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: ir -> {class, rd, rs, alu_op, illegal}.
// MOV/ALU targeting r3 are illegal because r3's input is the data switch.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [7:0] i_ir,
  output dec_t       o_dec
);

  logic [3:0] w_op;
  logic       w_rd3;

  assign w_op  = i_ir[7:4];
  assign w_rd3 = (i_ir[3:2] == 2'd3);

  // Classify opcode and extract fields
  always_comb begin
    o_dec        = '0;
    o_dec.rd     = i_ir[3:2];
    o_dec.rs     = i_ir[1:0];
    // op-2 for ADD..OR, which only depends on the low opcode bits
    o_dec.alu_op = i_ir[5:4] - 2'd2;
    case (w_op)
      OP_NOP:                      o_dec.cls = CL_NOP;
      OP_MOV:                      o_dec.cls = w_rd3 ? CL_ILL : CL_MOV;
      OP_ADD, OP_SUB, OP_AND, OP_OR: o_dec.cls = w_rd3 ? CL_ILL : CL_ALU;
      OP_LDS:                      o_dec.cls = CL_LDS;
      OP_JMP:                      o_dec.cls = CL_JMP;
      OP_HLT:                      o_dec.cls = CL_HLT;
      default:                     o_dec.cls = CL_ILL;
    endcase
    o_dec.illegal = (o_dec.cls == CL_ILL);
  end

endmodule

// File: rtl/ctrl_seq.sv
// Fetch/decode/execute sequencer for the 8-bit core. Owns the FSM, pc and ir;
// drives register-file write enables, read select and ALU controls.
// Optional feature: define SINGLE_STEP_EN to add a 'step' input that gates
// FETCH so each rising edge of step retires exactly one instruction.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      instr,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] pc,
  output logic            ce0,
  output logic            ce1,
  output logic            ce2,
  output logic            ce3,
  output logic [1:0]      addr,
  output logic            alu_a_ld,
  output logic [1:0]      alu_op,
  output logic            wb_mov,
  output logic            halted,
  output logic            illegal
);

  state_e          r_state;
  logic [7:0]      r_ir;
  logic [PC_W-1:0] r_pc;
  logic [1:0]      r_alu_op;
  logic            r_wb_mov;
  logic            r_halted;
  logic            r_illegal;

  dec_t            w_dec;     // decode of the latched instruction
  dec_t            w_dec_in;  // decode of the ROM word, used only for the early illegal flag
  logic            w_go;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_imm;
  logic [3:0]      w_ce;
  logic [1:0]      w_addr;
  logic            w_ald;

  ctrl_decode u_dec_ir (.i_ir(r_ir),  .o_dec(w_dec));
  ctrl_decode u_dec_in (.i_ir(instr), .o_dec(w_dec_in));

  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_imm    = PC_W'(r_ir[3:0]);

`ifdef SINGLE_STEP_EN
  logic r_step_q;
  logic r_step_pend;
  logic w_step_rise;

  assign w_step_rise = step & ~r_step_q;
  assign w_go        = r_step_pend | w_step_rise;

  // Step edge detect; a rise seen outside FETCH is held until FETCH consumes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_q    <= 1'b0;
      r_step_pend <= 1'b0;
    end else begin
      r_step_q <= step;
      if (r_state == ST_FETCH && w_go) r_step_pend <= 1'b0;
      else if (w_step_rise)            r_step_pend <= 1'b1;
    end
  end
`else
  assign w_go = 1'b1;
`endif

  // Main FSM with pc, ir and registered controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_ir      <= '0;
      r_pc      <= '0;
      r_alu_op  <= ALU_ADD;
      r_wb_mov  <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        ST_FETCH: if (w_go) begin
          r_ir      <= instr;
          // registered from the ROM word so the pulse lines up with DECODE
          r_illegal <= w_dec_in.illegal;
          r_state   <= ST_DECODE;
        end
        ST_DECODE: begin
          case (w_dec.cls)
            CL_NOP, CL_ILL: begin r_pc <= w_pc_inc; r_state <= ST_FETCH; end
            CL_JMP:         begin r_pc <= w_imm;    r_state <= ST_FETCH; end
            CL_HLT:         begin r_halted <= 1'b1; r_state <= ST_HALT;  end
            CL_LDS:         r_state <= ST_WRITE;
            CL_MOV:         begin r_wb_mov <= 1'b1; r_state <= ST_READ_B; end
            CL_ALU:         r_state <= ST_READ_A;
            default:        r_state <= ST_FETCH;
          endcase
        end
        ST_READ_A: begin
          // loaded on entry to READ_B and held through WRITE
          r_alu_op <= w_dec.alu_op;
          r_wb_mov <= 1'b0;
          r_state  <= ST_READ_B;
        end
        ST_READ_B: r_state <= ST_WRITE;
        ST_WRITE: begin
          r_pc    <= w_pc_inc;
          r_state <= ST_FETCH;
        end
        ST_HALT:  r_state <= ST_HALT;
        default:  r_state <= ST_FETCH;
      endcase
    end
  end

  // Moore decode of register-file controls from state and ir
  always_comb begin
    w_ce   = '0;
    w_addr = '0;
    w_ald  = 1'b0;
    case (r_state)
      ST_READ_A: begin
        w_addr = w_dec.rd;
        w_ald  = 1'b1;
      end
      ST_READ_B: w_addr = w_dec.rs;
      ST_WRITE: begin
        if (w_dec.cls == CL_LDS) begin
          w_ce[3] = 1'b1;
        end else begin
          w_addr          = w_dec.rs;
          w_ce[w_dec.rd]  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pc       = r_pc;
  assign {ce3, ce2, ce1, ce0} = w_ce;
  assign addr     = w_addr;
  assign alu_a_ld = w_ald;
  assign alu_op   = r_alu_op;
  assign wb_mov   = r_wb_mov;
  assign halted   = r_halted;
  assign illegal  = r_illegal;

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 8-bit core.
- Sits directly upstream of the 4-entry register file and drives its per-register write enables (ce0..ce3) and read-mux select (addr).
- Presents the PC to program ROM, latches the returned instruction word, and sequences ALU operand latch and writeback.

Parameters:
- PC_W, 4, program counter width; ROM depth is 2**PC_W.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  8  instruction word from ROM at address pc; valid combinationally during FETCH.
- pc  out  PC_W  program counter to ROM.
- ce0, ce1, ce2, ce3  out  1 each  register-file write enables; at most one high per cycle.
- addr  out  2  register-file read select.
- alu_a_ld  out  1  ALU operand-A latch enable (captures RF data_out).
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- wb_mov  out  1  1 = writeback passes RF data_out unchanged (MOV); 0 = ALU result.
- halted  out  1  high while in HALT.
- illegal  out  1  one-cycle pulse on an illegal instruction.

Behaviour:
- Instruction format: op = ir[7:4], rd = ir[3:2], rs = ir[1:0], imm = ir[3:0].
- Opcodes:
  - 0 NOP
  - 1 MOV rd<-rs
  - 2 ADD, 3 SUB, 4 AND, 5 OR (rd<-rd op rs)
  - 6 LDS (r3<-data_switch via ce3)
  - 7 JMP (pc<-imm, zero-extended/truncated to PC_W)
  - F HLT
  - All others illegal.
- States: FETCH, DECODE, READ_A, READ_B, WRITE, HALT.
- Reset (asynchronous, any state, including mid-instruction): state=FETCH, pc=0, ir=0, all ce*=0, addr=0, alu_a_ld=0, alu_op=0, wb_mov=0, halted=0, illegal=0.
- FETCH: ir<=instr; next DECODE.
- DECODE:
  - NOP: pc+1, -> FETCH.
  - JMP: pc<=imm, -> FETCH.
  - HLT: -> HALT.
  - LDS: -> WRITE.
  - MOV: -> READ_B.
  - ALU ops: -> READ_A.
  - Illegal: illegal=1 for this cycle, pc+1, -> FETCH.
- READ_A: addr=rd, alu_a_ld=1; -> READ_B.
- READ_B: addr=rs; alu_op=op-2 for ALU ops; wb_mov=1 for MOV; -> WRITE.
- WRITE:
  - Assert the ce of rd (ce3 for LDS) for exactly this cycle.
  - addr, alu_op and wb_mov hold their READ_B values, so the result is stable at the write edge.
  - pc+1; -> FETCH.
- HALT: all ce*=0, halted=1, pc frozen; exit only via reset.
- rd=3 with MOV or ALU ops: r3 input is hard-wired to data_switch, so this is illegal. Treated as illegal at DECODE; no write occurs.
- Cycle counts: NOP/JMP/illegal 2; LDS 3; MOV 4; ALU 5.
- pc wraps 2**PC_W-1 -> 0 on increment.
- Outputs are registered, except addr, ce* and alu_a_ld, which are decoded from state+ir (Moore, glitch-free at the clock edge).

Optional Feature:
- Macro SINGLE_STEP_EN.
- When defined: extra input step (1 bit). FETCH holds (no ir load, no transition) until a step rising edge, detected with a synchronous edge-detect register reset to 0.
- Instructions already past FETCH complete normally. Each step pulse executes exactly one instruction.
- When undefined: no step port; FETCH always advances.

Decomposition:
- Shared package ctrl_pkg: opcode constants (OP_NOP..OP_HLT), state encoding, ALU op codes, default PC_W.
- The same ALU op codes are used by the ALU block.
- One natural sub-module, ctrl_decode: combinational, maps ir to {class, rd, rs, alu_op, illegal}.
- ctrl_seq holds the FSM, pc and ir.

Test Plan:
- Reset mid-WRITE of ADD (rst_n low for 1 cycle) -> all ce*=0 immediately; pc=0, state FETCH; no write edge seen by the register file.
- ROM {0x61 LDS, 0x13 MOV r0<-r3, 0x20 ADD r0<-r0+r0, 0xF0} -> ce3 pulse at cycle 3; ce0 at cycles 7 and 12; ADD READ_A addr=0, alu_a_ld=1; HLT -> halted=1, pc=3 frozen for 20 cycles.
- 0x7A JMP at pc=0 with PC_W=4 -> pc=10 after 2 cycles; no ce asserted.
- 0x1C MOV r3<-r0 -> illegal pulse exactly 1 cycle; no ce3; pc advances by 1.
- Program of 16 NOPs -> pc reaches 15 then wraps to 0 after 32 cycles.
- SINGLE_STEP_EN: step held low 10 cycles -> pc unchanged; one step pulse -> exactly one instruction retires.
